// File: rtl/apb_spi_mbox_if.sv
// APB bus bundle between the SPI-to-APB bridge (master) and the mailbox block (slave).
interface apb_spi_mbox_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  modport master (
    output psel, penable, paddr, pwrite, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_spi_mbox.sv
// APB mailbox slave: ID/scratch/control/status registers plus TX and RX mailbox FIFOs
// bridging APB transfers from the SPI host to on-chip valid/ready streams.
module apb_spi_mbox #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned WAIT_STATES    = 0,
  parameter logic [31:0] ID_VALUE       = 32'h5350_4D42
) (
  input  logic                      apb_pclk_i,
  input  logic                      apb_preset_i,
  apb_spi_mbox_if.slave             apb,
  output logic [APB_DATA_WIDTH-1:0] mbx_tx_data_o,
  output logic                      mbx_tx_valid_o,
  input  logic                      mbx_tx_ready_i,
  input  logic [APB_DATA_WIDTH-1:0] mbx_rx_data_i,
  input  logic                      mbx_rx_valid_i,
  output logic                      mbx_rx_ready_o,
  output logic                      irq_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [3:0]    WAIT_C  = 4'(WAIT_STATES);

  typedef logic [APB_DATA_WIDTH-1:0]                  word_t;
  typedef logic [FIFO_DEPTH-1:0][APB_DATA_WIDTH-1:0] mem_t;

  typedef enum logic [2:0] {
    REG_ID      = 3'd0,
    REG_STATUS  = 3'd1,
    REG_CTRL    = 3'd2,
    REG_TXDATA  = 3'd3,
    REG_RXDATA  = 3'd4,
    REG_SCRATCH = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } reg_sel_e;

  // State
  logic [3:0]    wcnt_q,      wcnt_d;
  mem_t          tx_mem_q,    tx_mem_d;
  logic [PW-1:0] tx_wptr_q,   tx_wptr_d;
  logic [PW-1:0] tx_rptr_q,   tx_rptr_d;
  logic [CW-1:0] tx_cnt_q,    tx_cnt_d;
  mem_t          rx_mem_q,    rx_mem_d;
  logic [PW-1:0] rx_wptr_q,   rx_wptr_d;
  logic [PW-1:0] rx_rptr_q,   rx_rptr_d;
  logic [CW-1:0] rx_cnt_q,    rx_cnt_d;
  logic          tx_ovf_q,    tx_ovf_d;
  logic          rx_unf_q,    rx_unf_d;
  logic          irq_en_rx_q, irq_en_rx_d;
  logic          irq_en_err_q, irq_en_err_d;
  word_t         scratch_q,   scratch_d;
  logic          irq_q,       irq_d;

  // Transfer decode
  reg_sel_e sel;
  logic     access, xfer_done, wr_done, rd_done;
  logic     ctrl_wr, status_wr, scratch_wr, tx_push_req, rx_pop_req;
  logic     tx_flush, rx_flush;
  logic     tx_full, tx_empty, tx_push, tx_pop;
  logic     rx_full, rx_empty, rx_push, rx_pop;
  word_t    rx_head, rdata;
  logic     unused_addr_bits;

  assign sel       = reg_sel_e'(apb.paddr[4:2]);
  assign access    = apb.psel & apb.penable;
  assign apb.pready = access & (wcnt_q == WAIT_C);
  assign xfer_done = access & apb.pready;
  assign wr_done   = xfer_done & apb.pwrite;
  assign rd_done   = xfer_done & ~apb.pwrite;

  assign ctrl_wr     = wr_done & (sel == REG_CTRL);
  assign status_wr   = wr_done & (sel == REG_STATUS);
  assign scratch_wr  = wr_done & (sel == REG_SCRATCH);
  assign tx_push_req = wr_done & (sel == REG_TXDATA);
  assign rx_pop_req  = rd_done & (sel == REG_RXDATA);
  assign tx_flush    = ctrl_wr & apb.pwdata[8];
  assign rx_flush    = ctrl_wr & apb.pwdata[9];

  // Full/empty come from the registered counts, so a same-cycle pop never frees room for a push.
  assign tx_full  = (tx_cnt_q == DEPTH_C);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = tx_push_req & ~tx_full;
  assign tx_pop   = ~tx_empty & mbx_tx_ready_i;

  assign rx_full  = (rx_cnt_q == DEPTH_C);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_push  = mbx_rx_valid_i & ~rx_full;
  assign rx_pop   = rx_pop_req & ~rx_empty;
  assign rx_head  = rx_empty ? '0 : rx_mem_q[rx_rptr_q];

  assign mbx_tx_data_o  = tx_mem_q[tx_rptr_q];
  assign mbx_tx_valid_o = ~tx_empty;
  assign mbx_rx_ready_o = ~rx_full;
  assign irq_o          = irq_q;

  assign unused_addr_bits = ^{apb.paddr[APB_ADDR_WIDTH-1:5], apb.paddr[1:0]};

  // NOTE: every variable gets its hold value before any branch so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    wcnt_d       = (access && !apb.pready) ? wcnt_q + 4'd1 : 4'd0;

    tx_mem_d     = tx_mem_q;
    tx_wptr_d    = tx_wptr_q;
    tx_rptr_d    = tx_rptr_q;
    tx_cnt_d     = tx_cnt_q;
    rx_mem_d     = rx_mem_q;
    rx_wptr_d    = rx_wptr_q;
    rx_rptr_d    = rx_rptr_q;
    rx_cnt_d     = rx_cnt_q;
    irq_en_rx_d  = irq_en_rx_q;
    irq_en_err_d = irq_en_err_q;
    scratch_d    = scratch_q;

    if (tx_push) tx_mem_d[tx_wptr_q] = apb.pwdata;
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + PW'(1);
      if (tx_pop)  tx_rptr_d = tx_rptr_q + PW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
        2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
        default: tx_cnt_d = tx_cnt_q;
      endcase
    end

    if (rx_push) rx_mem_d[rx_wptr_q] = mbx_rx_data_i;
    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + PW'(1);
      if (rx_pop)  rx_rptr_d = rx_rptr_q + PW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
        2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
        default: rx_cnt_d = rx_cnt_q;
      endcase
    end

    // A new error event wins over a W1C clear landing in the same cycle.
    tx_ovf_d = (tx_push_req & tx_full)  | (tx_ovf_q & ~(status_wr & apb.pwdata[4]));
    rx_unf_d = (rx_pop_req  & rx_empty) | (rx_unf_q & ~(status_wr & apb.pwdata[5]));

    if (ctrl_wr) begin
      irq_en_rx_d  = apb.pwdata[0];
      irq_en_err_d = apb.pwdata[1];
    end
    if (scratch_wr) scratch_d = apb.pwdata;

    irq_d = (irq_en_rx_q & ~rx_empty) | (irq_en_err_q & (tx_ovf_q | rx_unf_q));
  end

  always_comb begin
    rdata = '0;
    case (sel)
      REG_ID:      rdata = word_t'(ID_VALUE);
      REG_STATUS: begin
        rdata[0]     = tx_full;
        rdata[1]     = tx_empty;
        rdata[2]     = rx_full;
        rdata[3]     = rx_empty;
        rdata[4]     = tx_ovf_q;
        rdata[5]     = rx_unf_q;
        rdata[15:8]  = 8'(tx_cnt_q);
        rdata[23:16] = 8'(rx_cnt_q);
      end
      REG_CTRL: begin
        rdata[0] = irq_en_rx_q;
        rdata[1] = irq_en_err_q;
      end
      REG_RXDATA:  rdata = rx_head;
      REG_SCRATCH: rdata = scratch_q;
      default:     rdata = '0;
    endcase
  end

  assign apb.prdata = rd_done ? rdata : '0;

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge apb_pclk_i) begin
    if (apb_preset_i) begin
      wcnt_q       <= '0;
      // NOTE: the mailbox storage is cleared too, so the TX head output reads 0 straight out of reset.
      tx_mem_q     <= '0;
      tx_wptr_q    <= '0;
      tx_rptr_q    <= '0;
      tx_cnt_q     <= '0;
      rx_mem_q     <= '0;
      rx_wptr_q    <= '0;
      rx_rptr_q    <= '0;
      rx_cnt_q     <= '0;
      tx_ovf_q     <= 1'b0;
      rx_unf_q     <= 1'b0;
      irq_en_rx_q  <= 1'b0;
      irq_en_err_q <= 1'b0;
      scratch_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      wcnt_q       <= wcnt_d;
      tx_mem_q     <= tx_mem_d;
      tx_wptr_q    <= tx_wptr_d;
      tx_rptr_q    <= tx_rptr_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_mem_q     <= rx_mem_d;
      rx_wptr_q    <= rx_wptr_d;
      rx_rptr_q    <= rx_rptr_d;
      rx_cnt_q     <= rx_cnt_d;
      tx_ovf_q     <= tx_ovf_d;
      rx_unf_q     <= rx_unf_d;
      irq_en_rx_q  <= irq_en_rx_d;
      irq_en_err_q <= irq_en_err_d;
      scratch_q    <= scratch_d;
      irq_q        <= irq_d;
    end
  end

endmodule

// File: tb/tb_apb_spi_mbox.sv
// Directed self-checking bench for apb_spi_mbox: one instance with no wait states
// and one with three, driven through the APB interface.
module tb_apb_spi_mbox;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] ID = 32'h5350_4D42;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  apb_spi_mbox_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  apb_spi_mbox_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

  logic [DW-1:0] tx_data0, tx_data3, rx_data, rx_data3;
  logic          tx_valid0, tx_valid3, tx_ready, tx_ready3;
  logic          rx_valid, rx_valid3, rx_ready0, rx_ready3;
  logic          irq0, irq3;

  logic [31:0] rd_tmp;
  int          cyc_tmp;

  apb_spi_mbox #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .FIFO_DEPTH(4),
                 .WAIT_STATES(0), .ID_VALUE(ID)) u_dut0 (
    .apb_pclk_i     (clk),
    .apb_preset_i   (rst),
    .apb            (bus0.slave),
    .mbx_tx_data_o  (tx_data0),
    .mbx_tx_valid_o (tx_valid0),
    .mbx_tx_ready_i (tx_ready),
    .mbx_rx_data_i  (rx_data),
    .mbx_rx_valid_i (rx_valid),
    .mbx_rx_ready_o (rx_ready0),
    .irq_o          (irq0)
  );

  apb_spi_mbox #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .FIFO_DEPTH(4),
                 .WAIT_STATES(3), .ID_VALUE(ID)) u_dut3 (
    .apb_pclk_i     (clk),
    .apb_preset_i   (rst),
    .apb            (bus3.slave),
    .mbx_tx_data_o  (tx_data3),
    .mbx_tx_valid_o (tx_valid3),
    .mbx_tx_ready_i (tx_ready3),
    .mbx_rx_data_i  (rx_data3),
    .mbx_rx_valid_i (rx_valid3),
    .mbx_rx_ready_o (rx_ready3),
    .irq_o          (irq3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit d3, input logic s, input logic en, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d3) begin
      bus3.psel = s; bus3.penable = en; bus3.pwrite = wr; bus3.paddr = a; bus3.pwdata = wd;
    end else begin
      bus0.psel = s; bus0.penable = en; bus0.pwrite = wr; bus0.paddr = a; bus0.pwdata = wd;
    end
  endtask

  // One APB transfer; returns read data and the number of access cycles up to pready.
  task automatic apb(input bit d3, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input bit rx_push_on_access, output logic [31:0] rd, output int cyc);
    bit rdy = 1'b0;
    rd  = '0;
    cyc = 0;
    drive(d3, 1'b1, 1'b0, wr, a, wd);
    @(posedge clk); #1;
    drive(d3, 1'b1, 1'b1, wr, a, wd);
    if (rx_push_on_access) rx_valid = 1'b1;
    while (!rdy && cyc < 32) begin
      @(negedge clk);
      cyc++;
      rdy = d3 ? bus3.pready : bus0.pready;
      if (rdy) rd = d3 ? bus3.prdata : bus0.prdata;
      @(posedge clk); #1;
    end
    if (rx_push_on_access) rx_valid = 1'b0;
    drive(d3, 1'b0, 1'b0, 1'b0, '0, '0);
    check("pready_timeout", {31'b0, rdy}, 32'd1);
  endtask

  task automatic wr0(input logic [31:0] a, input logic [31:0] d);
    apb(1'b0, 1'b1, a, d, 1'b0, rd_tmp, cyc_tmp);
  endtask

  task automatic rd0(input string tag, input logic [31:0] a, input logic [31:0] exp);
    apb(1'b0, 1'b0, a, '0, 1'b0, rd_tmp, cyc_tmp);
    check(tag, rd_tmp, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tx_ready3 = 1'b0; rx_valid3 = 1'b0; rx_data3 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_prdata",   bus0.prdata, 32'h0);
    check("rst_pready",   {31'b0, bus0.pready}, 32'h0);
    check("rst_irq",      {31'b0, irq0}, 32'h0);
    check("rst_tx_valid", {31'b0, tx_valid0}, 32'h0);
    check("rst_tx_data",  tx_data0, 32'h0);
    rst = 1'b0;

    // Basic register reads with zero wait states
    apb(1'b0, 1'b0, 32'h00, '0, 1'b0, rd_tmp, cyc_tmp);
    check("id_read", rd_tmp, ID);
    check("ws0_access_cycles", cyc_tmp, 32'd1);
    rd0("status_reset", 32'h04, 32'h0000_000A);
    rd0("scratch_reset", 32'h14, 32'h0);

    // Three wait states: ready in the fourth access cycle
    apb(1'b1, 1'b1, 32'h14, 32'hDEAD_BEEF, 1'b0, rd_tmp, cyc_tmp);
    check("ws3_write_cycles", cyc_tmp, 32'd4);
    apb(1'b1, 1'b0, 32'h14, '0, 1'b0, rd_tmp, cyc_tmp);
    check("ws3_read_cycles", cyc_tmp, 32'd4);
    check("ws3_scratch_rd", rd_tmp, 32'hDEAD_BEEF);

    // TX overflow: five pushes into a depth-4 FIFO with the consumer stalled
    for (int i = 0; i < 5; i++) wr0(32'h0C, 32'h1001 + i);
    rd0("status_tx_ovf", 32'h04, 32'h0000_0419);
    check("tx_valid_full", {31'b0, tx_valid0}, 32'h1);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tx_drain_valid", {31'b0, tx_valid0}, 32'h1);
      check("tx_drain_data", tx_data0, 32'h1001 + i);
    end
    @(negedge clk);
    check("tx_drained_valid", {31'b0, tx_valid0}, 32'h0);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    wr0(32'h04, 32'h10);
    rd0("status_ovf_clr", 32'h04, 32'h0000_000A);

    // RX underflow and error interrupt
    wr0(32'h08, 32'h2);
    check("irq_err_idle", {31'b0, irq0}, 32'h0);
    rd0("rx_unf_data", 32'h10, 32'h0);
    check("irq_err_lat0", {31'b0, irq0}, 32'h0);
    @(posedge clk); #1;
    check("irq_err_rise", {31'b0, irq0}, 32'h1);
    rd0("status_rx_unf", 32'h04, 32'h0000_002A);
    wr0(32'h04, 32'h20);
    check("irq_err_hold", {31'b0, irq0}, 32'h1);
    @(posedge clk); #1;
    check("irq_err_fall", {31'b0, irq0}, 32'h0);
    rd0("status_unf_clr", 32'h04, 32'h0000_000A);

    // RX stream push and receive interrupt
    rx_valid = 1'b1; rx_data = 32'h11;
    @(posedge clk); #1;
    rx_data = 32'h22;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rd0("status_rx2", 32'h04, 32'h0002_0002);
    check("irq_rx_off", {31'b0, irq0}, 32'h0);
    wr0(32'h08, 32'h3);
    @(posedge clk); #1;
    check("irq_rx_on", {31'b0, irq0}, 32'h1);
    rd0("ctrl_read", 32'h08, 32'h3);
    rd0("rx_pop1", 32'h10, 32'h11);
    check("irq_rx_one_left", {31'b0, irq0}, 32'h1);
    rd0("rx_pop2", 32'h10, 32'h22);
    check("irq_rx_lat", {31'b0, irq0}, 32'h1);
    @(posedge clk); #1;
    check("irq_rx_fall", {31'b0, irq0}, 32'h0);

    // RX full with producer held valid
    rx_valid = 1'b1; rx_data = 32'h31;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      rx_data = 32'h31 + i;
    end
    @(negedge clk);
    check("rx_ready_full", {31'b0, rx_ready0}, 32'h0);
    rd0("status_rx_full", 32'h04, 32'h0004_0006);
    rd0("rx_pop_full", 32'h10, 32'h31);
    check("rx_ready_after_pop", {31'b0, rx_ready0}, 32'h1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rd0("status_refilled", 32'h04, 32'h0004_0006);
    rd0("rx_pop_32", 32'h10, 32'h32);
    rx_data = 32'h36;
    apb(1'b0, 1'b0, 32'h10, '0, 1'b1, rd_tmp, cyc_tmp);
    check("rx_pushpop_data", rd_tmp, 32'h33);
    rd0("status_pushpop", 32'h04, 32'h0003_0002);
    rd0("rx_pop_34", 32'h10, 32'h34);
    rd0("rx_pop_35", 32'h10, 32'h35);
    rd0("rx_pop_36", 32'h10, 32'h36);
    rd0("status_rx_empty", 32'h04, 32'h0000_000A);

    // TX flush
    wr0(32'h0C, 32'h2001);
    wr0(32'h0C, 32'h2002);
    check("tx_valid_two", {31'b0, tx_valid0}, 32'h1);
    rd0("status_tx2", 32'h04, 32'h0000_0208);
    wr0(32'h08, 32'h100);
    check("tx_valid_flushed", {31'b0, tx_valid0}, 32'h0);
    rd0("status_flushed", 32'h04, 32'h0000_000A);
    rd0("ctrl_flush_reads0", 32'h08, 32'h0);

    // Aliasing and reserved locations
    rd0("alias_id", 32'h20, ID);
    rd0("rsvd_18", 32'h18, 32'h0);
    rd0("txdata_reads0", 32'h0C, 32'h0);
    wr0(32'h1C, 32'hFFFF_FFFF);
    rd0("alias_scratch", 32'h34, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
